// File: rtl/fifo_reader_if.sv
// Signal bundle between fifo_reader, its source fifo and the downstream consumer.
// master is the reader side; slave is the fifo-plus-consumer side.
interface fifo_reader_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_r;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  m_ready,
        output fifo_r,
        output m_data,
        output m_valid
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output m_ready,
        input  fifo_r,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_reader.sv
// Read-side adapter for the synchronous fifo: pops on the fifo's empty flag into a
// 2-entry prefetch/skid store and re-presents the words as a registered valid/ready stream.
module fifo_reader #(
    parameter int    WIDTH = 1,
    parameter string CLEAR = "none"
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    output logic          idle,
    fifo_reader_if.master bus
);
    typedef enum logic [1:0] {S0, S1, S2} state_t;

    localparam bit CLR_EN = (CLEAR == "sync");

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e0_nxt;
    logic [WIDTH-1:0] e1_nxt;
    logic             valid_q;
    logic             clr_int;
    logic             pop;
    logic             out;

    assign clr_int = CLR_EN & clr;

    // The pop never looks at m_ready, so consumer backpressure cannot reach the fifo combinationally.
    assign pop = rstn & ~bus.fifo_empty & ~clr_int & (state != S2);
    assign out = valid_q & bus.m_ready;

    assign bus.fifo_r  = pop;
    assign bus.m_data  = e0;
    assign bus.m_valid = valid_q;
    assign idle        = (state == S0) & bus.fifo_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S0;
            e0      <= '0;
            e1      <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            e0      <= e0_nxt;
            e1      <= e1_nxt;
            valid_q <= (state_nxt != S0);
        end
    end

    // e0 is the head and always feeds m_data; entries are left stale when drained.
    always_comb begin
        state_nxt = state;
        e0_nxt    = e0;
        e1_nxt    = e1;
        if (clr_int) begin
            state_nxt = S0;
        end else begin
            case (state)
                S0: begin
                    if (pop) begin
                        state_nxt = S1;
                        e0_nxt    = bus.fifo_dout;
                    end
                end
                S1: begin
                    if (pop && !out) begin
                        state_nxt = S2;
                        e1_nxt    = bus.fifo_dout;
                    end else if (pop && out) begin
                        e0_nxt = bus.fifo_dout;
                    end else if (out) begin
                        state_nxt = S0;
                    end
                end
                S2: begin
                    if (out) begin
                        state_nxt = S1;
                        e0_nxt    = e1;
                    end
                end
                default: begin
                    state_nxt = S0;
                end
            endcase
        end
    end
endmodule
